// File: rtl/reg_bank_arbiter.sv
// Config/status register bank shared by two requesters (A: SPI engine, B: local master).
// Arbitration is round-robin with an optional burst lock, and the lock is capped at MAX_LOCK grants.
// Each access takes one grant cycle followed by one ack cycle.
module reg_bank_arbiter #(
  parameter int unsigned          NUM_REGS  = 16,
  parameter int unsigned          REG_WIDTH = 8,
  parameter int unsigned          ADDR_W    = 5,
  parameter logic [REG_WIDTH-1:0] CFG_RESET = '0,
  parameter int unsigned          MAX_LOCK  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          a_req,
  input  logic                          b_req,
  input  logic                          a_we,
  input  logic                          b_we,
  input  logic                          a_lock,
  input  logic                          b_lock,
  input  logic [ADDR_W-1:0]             a_addr,
  input  logic [ADDR_W-1:0]             b_addr,
  input  logic [REG_WIDTH-1:0]          a_wdata,
  input  logic [REG_WIDTH-1:0]          b_wdata,
  output logic                          a_gnt,
  output logic                          b_gnt,
  output logic                          a_ack,
  output logic                          b_ack,
  output logic                          a_err,
  output logic                          b_err,
  output logic [REG_WIDTH-1:0]          a_rdata,
  output logic [REG_WIDTH-1:0]          b_rdata,
  output logic [NUM_REGS*REG_WIDTH-1:0] config_regs,
  input  logic [NUM_REGS*REG_WIDTH-1:0] status_regs
);

  localparam int unsigned IDX_W = ADDR_W - 1;
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic        SRV_A = 1'b0;
  localparam logic        SRV_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t               state_q;
  logic                 last_served_q;
  logic [CNT_W-1:0]     lock_cnt_q;
  logic                 a_gnt_q, b_gnt_q, a_ack_q, b_ack_q, a_err_q, b_err_q;
  logic [REG_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [REG_WIDTH-1:0] cfg_q [NUM_REGS];
  logic [REG_WIDTH-1:0] status_arr [NUM_REGS];

  logic                 hold_req, lock_hold, rr_a, rr_b, pick_a, pick_b;
  logic [ADDR_W-1:0]    acc_addr;
  logic                 acc_we;
  logic [REG_WIDTH-1:0] acc_wdata;
  logic [IDX_W-1:0]     acc_idx;
  logic                 acc_is_status, acc_in_range;
  logic [REG_WIDTH-1:0] acc_rdata;
  logic                 acc_err, acc_wr;

  // Flat port vectors <-> per-register arrays
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
    assign status_arr[g] = status_regs[g*REG_WIDTH +: REG_WIDTH];
  end

  assign a_gnt   = a_gnt_q;
  assign b_gnt   = b_gnt_q;
  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_err   = a_err_q;
  assign b_err   = b_err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

  // Next grant: a burst lock on the just-served requester overrides round-robin until the cap is reached
  always_comb begin
    hold_req  = (last_served_q == SRV_A) ? (a_req && a_lock) : (b_req && b_lock);
    lock_hold = (state_q == ACK) && hold_req && (lock_cnt_q < CNT_W'(MAX_LOCK - 1));
    rr_a      = a_req && (!b_req || (last_served_q == SRV_B));
    rr_b      = b_req && (!a_req || (last_served_q == SRV_A));
    pick_a    = lock_hold ? (last_served_q == SRV_A) : rr_a;
    pick_b    = lock_hold ? (last_served_q == SRV_B) : rr_b;
  end

  // Decode the access of the requester currently granted
  always_comb begin
    acc_addr      = (state_q == GNT_B) ? b_addr  : a_addr;
    acc_we        = (state_q == GNT_B) ? b_we    : a_we;
    acc_wdata     = (state_q == GNT_B) ? b_wdata : a_wdata;
    acc_is_status = acc_addr[ADDR_W-1];
    acc_idx       = acc_addr[IDX_W-1:0];
    acc_in_range  = 32'(acc_idx) < NUM_REGS;
    acc_rdata     = '0;
    acc_err       = 1'b1;
    acc_wr        = 1'b0;
    if (acc_in_range) begin
      if (acc_is_status) begin
        acc_rdata = status_arr[acc_idx];
        acc_err   = acc_we;
      end else begin
        acc_rdata = cfg_q[acc_idx];
        acc_err   = 1'b0;
        acc_wr    = acc_we;
      end
    end
  end

  // Arbitration FSM with registered grant/ack/err/rdata outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= SRV_B;
      lock_cnt_q    <= '0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_err_q       <= 1'b0;
      b_err_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else if (ena) begin
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      case (state_q)
        IDLE, ACK: begin
          if (pick_a) begin
            state_q <= GNT_A;
            a_gnt_q <= 1'b1;
          end else if (pick_b) begin
            state_q <= GNT_B;
            b_gnt_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
          lock_cnt_q <= lock_hold ? lock_cnt_q + CNT_W'(1) : '0;
        end
        GNT_A: begin
          state_q       <= ACK;
          last_served_q <= SRV_A;
          a_ack_q       <= 1'b1;
          a_err_q       <= acc_err;
          a_rdata_q     <= acc_rdata;
        end
        GNT_B: begin
          state_q       <= ACK;
          last_served_q <= SRV_B;
          b_ack_q       <= 1'b1;
          b_err_q       <= acc_err;
          b_rdata_q     <= acc_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Config write commits at the end of the grant cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= CFG_RESET;
    end else if (ena && ((state_q == GNT_A) || (state_q == GNT_B)) && acc_wr) begin
      cfg_q[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: stimulus pushes expected {rdata,err} per requester,
// a negedge monitor pops and compares on every fresh ack.
module tb_reg_bank_arbiter;

  logic         clk = 1'b0;
  logic         rst, ena;
  logic         a_req, b_req, a_we, b_we, a_lock, b_lock;
  logic [4:0]   a_addr, b_addr;
  logic [7:0]   a_wdata, b_wdata;
  logic         a_gnt, b_gnt, a_ack, b_ack, a_err, b_err;
  logic [7:0]   a_rdata, b_rdata;
  logic [127:0] config_regs, status_regs;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           overlap_cnt = 0;
  logic [8:0]   qa[$];
  logic [8:0]   qb[$];
  string        glog = "";
  logic         ena_at_edge = 1'b1;
  int           la, lb;
  int           ack_seen;
  logic [127:0] exp_cfg;

  reg_bank_arbiter dut (
    .clk(clk), .rst(rst), .ena(ena),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_lock(a_lock), .b_lock(b_lock), .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ack(a_ack), .b_ack(b_ack),
    .a_err(a_err), .b_err(b_err), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .config_regs(config_regs), .status_regs(status_regs)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Issue one access on A (is_b=0) or B and wait for its ack; req is left high for back-to-back use
  task automatic access(input bit is_b, input logic we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err,
                        output int lat);
    if (is_b) begin
      qb.push_back({exp_rd, exp_err});
      b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      qa.push_back({exp_rd, exp_err});
      a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (is_b ? b_ack : a_ack) break;
      if (lat >= 30) begin
        check(is_b ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) ena_at_edge <= ena;

  // Monitor: grant log, exclusivity, and scoreboard compare on each fresh ack
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if ((a_gnt && b_gnt) || (a_ack && b_ack) || (a_gnt && b_ack) || (b_gnt && a_ack))
        overlap_cnt++;
      if (ena_at_edge && a_gnt) glog = {glog, "A"};
      if (ena_at_edge && b_gnt) glog = {glog, "B"};
      if (a_ack && ena_at_edge) begin
        if (qa.size() == 0) check("a_unexpected_ack", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_rdata", 128'(a_rdata), 128'(e[8:1]));
          check("a_err", 128'(a_err), 128'(e[0]));
        end
      end
      if (b_ack && ena_at_edge) begin
        if (qb.size() == 0) check("b_unexpected_ack", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_rdata", 128'(b_rdata), 128'(e[8:1]));
          check("b_err", 128'(b_err), 128'(e[0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ena = 1'b1; rst = 1'b1;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    for (int i = 0; i < 16; i++) status_regs[i*8 +: 8] = 8'(16 * i);
    status_regs[7:0]   = 8'h5C;
    status_regs[23:16] = 8'hAA;
    do_reset();

    // Reset state and first read latency
    check("rst_cfg", config_regs, '0);
    check("rst_gnt", 128'({a_gnt, b_gnt}), 0);
    check("rst_ack_err", 128'({a_ack, b_ack, a_err, b_err}), 0);
    check("rst_rdata", 128'({a_rdata, b_rdata}), 0);
    access(0, 0, 5'h03, 8'h00, 8'h00, 0, la);
    a_req = 0;
    check("a_latency", la, 2);

    // Write on A, read back on B
    access(0, 1, 5'h00, 8'hCA, 8'h00, 0, la);
    a_req = 0;
    access(1, 0, 5'h00, 8'h00, 8'hCA, 0, lb);
    b_req = 0;
    check("cfg0_after_write", 128'(config_regs[7:0]), 128'(8'hCA));

    // Simultaneous requests alternate A,B,A,... starting with A
    do_reset();
    check("cfg_cleared", config_regs, '0);
    glog = "";
    fork
      begin
        access(0, 1, 5'h01, 8'h11, 8'h00, 0, la);
        access(0, 1, 5'h02, 8'h22, 8'h00, 0, la);
        access(0, 0, 5'h01, 8'h00, 8'h11, 0, la);
        a_req = 0;
      end
      begin
        access(1, 0, 5'h10, 8'h00, 8'h5C, 0, lb);
        access(1, 0, 5'h11, 8'h00, 8'h10, 0, lb);
        access(1, 0, 5'h12, 8'h00, 8'hAA, 0, lb);
        b_req = 0;
      end
    join
    check("rr_order", 128'(glog == "ABABAB"), 1);
    if (glog != "ABABAB") $display("  grant order seen: %s", glog);
    check("cfg_1_2", 128'(config_regs[23:8]), 128'(16'h2211));

    // Burst lock: A locked for 5 accesses, B waiting -> AAAA B A
    glog = "";
    fork
      begin
        a_lock = 1;
        repeat (5) access(0, 0, 5'h01, 8'h00, 8'h11, 0, la);
        a_req = 0;
        a_lock = 0;
      end
      begin
        @(negedge clk);
        access(1, 0, 5'h02, 8'h00, 8'h22, 0, lb);
        b_req = 0;
      end
    join
    check("lock_order", 128'(glog == "AAAABA"), 1);
    if (glog != "AAAABA") $display("  grant order seen: %s", glog);

    // Status write is an error and leaves config untouched; status read is legal
    exp_cfg = '0;
    exp_cfg[15:8]  = 8'h11;
    exp_cfg[23:16] = 8'h22;
    access(1, 1, 5'h12, 8'h77, 8'hAA, 1, lb);
    b_req = 0;
    check("cfg_after_status_wr", config_regs, exp_cfg);
    access(0, 0, 5'h11, 8'h00, 8'h10, 0, la);
    a_req = 0;

    // Reset during GNT_A of a write aborts it with no ack
    a_we = 1; a_addr = 5'h05; a_wdata = 8'h5A; a_req = 1;
    @(negedge clk);
    if (!a_gnt) @(negedge clk);
    check("t6_gnt_a", 128'(a_gnt), 1);
    rst = 1; a_req = 0; a_we = 0;
    ack_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (a_ack) ack_seen++;
    end
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_ack) ack_seen++;
    end
    check("t6_no_ack", ack_seen, 0);
    check("t6_reg5", 128'(config_regs[47:40]), 0);
    check("t6_cfg_reset", config_regs, '0);

    // ena low during ACK freezes the ack until ena returns
    qa.push_back({8'h10, 1'b0});
    a_we = 0; a_addr = 5'h11; a_req = 1;
    @(negedge clk);
    check("t7_gnt", 128'(a_gnt), 1);
    @(negedge clk);
    check("t7_ack_on", 128'(a_ack), 1);
    ena = 0; a_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t7_ack_hold", 128'({a_ack, a_gnt}), 128'(2'b10));
    end
    ena = 1;
    @(negedge clk);
    check("t7_ack_clear", 128'(a_ack), 0);

    repeat (3) @(negedge clk);
    check("no_overlap", overlap_cnt, 0);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
